// File: rtl/imm_pkg.sv
// Shared definitions for the immediate/target sequencer: format codes, FSM
// states, SPARC field positions and the format decoder.
package imm_pkg;

  localparam int OP_HI  = 31;
  localparam int OP2_HI = 24;
  localparam int I_BIT  = 13;

  typedef enum logic [2:0] {
    FMT_SIMM13 = 3'd0,
    FMT_DISP22 = 3'd1,
    FMT_DISP30 = 3'd2,
    FMT_SETHI  = 3'd3,
    FMT_NONE   = 3'd4
  } fmt_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXT  = 2'd1,
    CALC = 2'd2,
    HOLD = 2'd3
  } state_e;

  function automatic fmt_e decode_fmt(input logic [31:0] instr);
    logic [1:0] op;
    logic [2:0] op2;
    logic       ibit;
    fmt_e       f;
    op   = instr[OP_HI -: 2];
    op2  = instr[OP2_HI -: 3];
    ibit = instr[I_BIT];
    f    = FMT_NONE;
    if (op == 2'b01)
      f = FMT_DISP30;
    else if (op == 2'b00 && op2 == 3'b010)
      f = FMT_DISP22;
    else if (op == 2'b00 && op2 == 3'b100)
      f = FMT_SETHI;
    else if (op[1] && ibit)
      f = FMT_SIMM13;
    return f;
  endfunction

endpackage

// File: rtl/imm_ext_unit.sv
// Combinational width-selectable extender: picks the immediate field named
// by the format code and sign- or zero-fills it to the datapath width.
module imm_ext_unit
  import imm_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [31:0]   instr,
  input  logic [2:0]    fmt,
  output logic [DW-1:0] imm_ext
);

  // The op field only matters to the decoder, never to the extension itself.
  logic unused_op;
  assign unused_op = ^instr[31:30];

  always_comb begin
    imm_ext = '0;
    unique case (fmt)
      FMT_SIMM13: imm_ext = {{(DW-13){instr[12]}}, instr[12:0]};
      FMT_DISP22: imm_ext = {{(DW-22){instr[21]}}, instr[21:0]};
      FMT_DISP30: imm_ext = {{(DW-30){instr[29]}}, instr[29:0]};
      FMT_SETHI:  imm_ext = {instr[21:0], {(DW-22){1'b0}}};
      default:    imm_ext = '0;
    endcase
  end

endmodule

// File: rtl/imm_target_seq.sv
// Four-state sequencer: accept instr/pc, extend the immediate, form the
// PC-relative target, then hold the result until the consumer takes it.
module imm_target_seq
  import imm_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   instr,
  input  logic [DW-1:0] pc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2:0]    fmt,
  output logic [DW-1:0] imm_ext,
  output logic [DW-1:0] target
);

  state_e        state, state_next;
  logic          accept;
  logic [31:0]   instr_p0;
  logic [DW-1:0] pc_p0;
  fmt_e          fmt_p0;
  logic [DW-1:0] ext_val;
  logic [DW-1:0] imm_p1;
  logic [DW-1:0] target_p2;

  // Word-aligned displacement: the offset is scaled by 4 in signed arithmetic
  // and the sum wraps modulo 2^DW.
  function automatic logic [DW-1:0] calc_target(input logic [DW-1:0] base,
                                                input logic [DW-1:0] imm,
                                                input fmt_e          f);
    logic signed [DW-1:0] off;
    logic        [DW-1:0] sum;
    off = $signed(imm) <<< 2;
    sum = base + $unsigned(off);
    if (f == FMT_DISP22 || f == FMT_DISP30)
      return sum;
    return base;
  endfunction

  assign accept = in_valid && (state == IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid) state_next = EXT;
      EXT:     state_next = CALC;
      CALC:    state_next = HOLD;
      HOLD:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == HOLD);
  end

  // Stage p0: capture the accepted instruction and its address.
  always_ff @(posedge clk) begin
    if (accept) begin
      instr_p0 <= instr;
      pc_p0    <= pc;
    end
  end

  imm_ext_unit #(.DW(DW)) u_ext (
    .instr   (instr_p0),
    .fmt     (fmt_p0),
    .imm_ext (ext_val)
  );

  // Stages p1/p2: extended immediate in EXT, target in CALC; both cleared on
  // reset so a discarded instruction leaves no trace on the outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fmt_p0    <= FMT_NONE;
      imm_p1    <= '0;
      target_p2 <= '0;
    end else begin
      if (accept)
        fmt_p0 <= decode_fmt(instr);
      if (state == EXT)
        imm_p1 <= ext_val;
      if (state == CALC)
        target_p2 <= calc_target(pc_p0, imm_p1, fmt_p0);
    end
  end

  assign fmt     = fmt_p0;
  assign imm_ext = imm_p1;
  assign target  = target_p2;

endmodule

// File: tb/tb_imm_target_seq.sv
// Self-checking bench for imm_target_seq: table of instr/pc vectors with
// hand-derived results, scoreboard queue, plus backpressure and reset cases.
module tb_imm_target_seq;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  fmt;
  logic [31:0] imm_ext;
  logic [31:0] target;

  imm_target_seq #(.DW(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .pc        (pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fmt       (fmt),
    .imm_ext   (imm_ext),
    .target    (target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic [31:0] target;
  } vec_t;

  typedef struct {
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic [31:0] target;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v, input int stall, input bit pulse);
    exp_t e;
    exp_t got;
    int   lat;
    e.fmt = v.fmt;
    e.imm = v.imm;
    e.target = v.target;
    sb.push_back(e);
    instr    = v.instr;
    pc       = v.pc;
    in_valid = 1'b1;
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    instr    = 32'hDEAD_BEEF;
    pc       = 32'h5555_AAAA;
    chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
    lat = 0;
    while (!out_valid && lat < 8) begin
      step();
      lat++;
    end
    chk("latency", lat, 32'd2);
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
      return;
    end
    got = sb.pop_front();
    chk("fmt", {29'd0, fmt}, {29'd0, got.fmt});
    chk("imm_ext", imm_ext, got.imm);
    chk("target", target, got.target);
    for (int j = 0; j < stall; j++) begin
      if (pulse && j == 1) begin
        in_valid = 1'b1;
        instr    = 32'h4000_0010;
        pc       = 32'h0000_0000;
      end
      step();
      in_valid = 1'b0;
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_fmt", {29'd0, fmt}, {29'd0, got.fmt});
      chk("hold_imm", imm_ext, got.imm);
      chk("hold_target", target, got.target);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("release_valid", {31'd0, out_valid}, 32'd0);
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    if (pulse) begin
      step();
      step();
      step();
      chk("ignored_pulse_valid", {31'd0, out_valid}, 32'd0);
    end
  endtask

  vec_t vecs[$];
  vec_t v;

  initial begin
    vecs.push_back('{32'h80A0_7FFF, 32'h0000_1000, 3'd0, 32'hFFFF_FFFF, 32'h0000_1000});
    vecs.push_back('{32'h10BF_FFFF, 32'h0000_0100, 3'd1, 32'hFFFF_FFFF, 32'h0000_00FC});
    vecs.push_back('{32'h4000_0001, 32'hFFFF_FFFC, 3'd2, 32'h0000_0001, 32'h0000_0000});
    vecs.push_back('{32'h033F_FFFF, 32'h0000_4000, 3'd3, 32'hFFFF_FC00, 32'h0000_4000});
    vecs.push_back('{32'h80A0_0001, 32'h0000_0200, 3'd4, 32'h0000_0000, 32'h0000_0200});
    vecs.push_back('{32'hC000_2005, 32'h0000_0300, 3'd0, 32'h0000_0005, 32'h0000_0300});
    vecs.push_back('{32'h0000_0123, 32'h0000_0400, 3'd4, 32'h0000_0000, 32'h0000_0400});
    vecs.push_back('{32'h0080_0010, 32'h0000_2000, 3'd1, 32'h0000_0010, 32'h0000_2040});
    vecs.push_back('{32'h7FFF_FFFF, 32'h0000_0010, 3'd2, 32'hFFFF_FFFF, 32'h0000_000C});
    vecs.push_back('{32'h6000_0000, 32'h0000_0000, 3'd2, 32'hE000_0000, 32'h8000_0000});
    vecs.push_back('{32'h0100_0000, 32'h1234_5678, 3'd3, 32'h0000_0000, 32'h1234_5678});

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    instr     = '0;
    pc        = '0;
    step();
    step();
    reset_n = 1'b1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_fmt", {29'd0, fmt}, 32'd4);
    chk("rst_imm", imm_ext, 32'd0);
    chk("rst_target", target, 32'd0);

    for (int k = 0; k < vecs.size(); k++)
      run_txn(vecs[k], 0, 1'b0);

    // Backpressure: five stalled cycles in HOLD with a stray in_valid pulse.
    run_txn(vecs[1], 5, 1'b1);

    // Reset while in CALC discards the instruction.
    instr    = 32'h4000_0001;
    pc       = 32'h0000_1000;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_imm", imm_ext, 32'd0);
    chk("midrst_target", target, 32'd0);
    chk("midrst_fmt", {29'd0, fmt}, 32'd4);
    step();
    step();
    step();
    chk("midrst_no_output", {31'd0, out_valid}, 32'd0);

    v = '{32'h0080_0010, 32'h0000_2000, 3'd1, 32'h0000_0010, 32'h0000_2040};
    run_txn(v, 2, 1'b0);

    chk("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
